segre_mm_arbiter: RTL and testbench
===================================

SEGRE_MM_ARBITER -- requirements
Module: segre_mm_arbiter

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 32, byte address width.
REQ-002 SHALL have parameter WORD_SIZE, default 32, store data width.
REQ-003 SHALL have parameter LANE_SIZE, default 128, cache lane (refill) width.
REQ-004 SHALL have port clk_i  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rsn_i  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have ports ic_req_i in 1, ic_addr_i in ADDR_SIZE, ic_rdy_o out 1, ic_data_o out LANE_SIZE: instruction-cache refill requester.
REQ-007 SHALL have ports dc_req_i in 1, dc_addr_i in ADDR_SIZE, dc_rdy_o out 1, dc_data_o out LANE_SIZE: data-cache refill requester.
REQ-008 SHALL have ports wr_req_i in 1, wr_addr_i in ADDR_SIZE, wr_data_i in WORD_SIZE, wr_type_i in memop_data_type_e, wr_done_o out 1: store write-back requester.
REQ-009 SHALL have ports mm_data_rdy_i in 1, mm_rd_data_i in LANE_SIZE: main-memory completion and read data.
REQ-010 SHALL have ports mm_rd_o out 1, mm_wr_o out 1, mm_addr_o out ADDR_SIZE, mm_wr_addr_o out ADDR_SIZE, mm_wr_data_o out WORD_SIZE, mm_wr_data_type_o out memop_data_type_e: main-memory request.

Function
REQ-011 SHALL implement FSM states IDLE, RD, WR, RESP.
REQ-012 Requesters SHALL hold req and address/data stable until their rdy/done pulse; arbiter SHALL sample only in IDLE.
REQ-013 In IDLE with any request, SHALL grant one requester that cycle, register its address (and data/type for writes) and a grant id, and move to RD (ic/dc) or WR (wr).
REQ-014 Priority SHALL be wr > dc > ic, except REQ-015.
REQ-015 A 2-bit starvation counter SHALL count consecutive non-ic grants while ic_req_i is high; at value 2, ic SHALL win the next arbitration; counter clears on ic grant or when ic_req_i is low at arbitration.
REQ-016 In RD, mm_rd_o SHALL be 1 and mm_addr_o SHALL be the registered address, lane-aligned (low log2(LANE_SIZE/8) bits zeroed); all outputs registered, so mm_rd_o first rises the cycle after grant.
REQ-017 In WR, mm_wr_o SHALL be 1 with mm_wr_addr_o, mm_wr_data_o, mm_wr_data_type_o from registered values (address not aligned).
REQ-018 On mm_data_rdy_i high in RD or WR, SHALL drop mm_rd_o/mm_wr_o next cycle and enter RESP; in RD, mm_rd_data_i captured that edge.
REQ-019 In RESP, SHALL assert exactly one of ic_rdy_o, dc_rdy_o, wr_done_o for one cycle per grant id; ic_data_o/dc_data_o valid then and held until that requester's next completion.
REQ-020 RESP SHALL always go to IDLE; no arbitration in RESP, so a requester dropping req on its rdy cycle is never re-granted.
REQ-021 mm_data_rdy_i in IDLE or RESP SHALL be ignored.
REQ-022 mm_rd_o and mm_wr_o SHALL never be high together; at most one outstanding main-memory transaction.
REQ-023 Minimum latency: grant cycle N, mm request from N+1, completion at M, rdy/done at M+1, next grant at M+2.

Reset
REQ-024 While rsn_i high, SHALL force IDLE, counter 0, all 1-bit outputs 0, all data/address outputs 0, types to their enum's first value, independent of clk_i.
REQ-025 Reset mid-transaction SHALL abandon it with no rdy/done pulse; mm_rd_o/mm_wr_o fall immediately.
REQ-026 After rsn_i falls, first arbitration SHALL occur at the first rising edge.

Verification
REQ-027 ic_req only, addr 0x0000_1234, memory ready 3 cycles later with data D -> mm_addr_o 0x0000_1230, mm_rd_o 3 cycles, ic_rdy_o one cycle, ic_data_o = D.
REQ-028 wr, dc, ic requested same cycle -> service order wr, dc, ic; one rdy/done per grant; mm_rd_o/mm_wr_o never simultaneous.
REQ-029 ic held, wr and dc re-requesting continuously -> ic granted no later than third arbitration.
REQ-030 rsn_i raised during RD -> mm_rd_o 0 immediately, no ic_rdy_o/dc_rdy_o; after release and re-request, normal completion.
REQ-031 Spurious mm_data_rdy_i in IDLE -> no rdy/done, no state change.
REQ-032 Store to 0x0000_0102, byte type, data 0xAB -> mm_wr_addr_o 0x0000_0102, type byte, data 0xAB, wr_done_o one cycle after mm_data_rdy_i.

Source files
------------

// File: rtl/segre_mm_arbiter.sv
// segre_mm_arbiter: shares one main-memory port between instruction-cache
// refills, data-cache refills and store write-backs. Only one memory
// transaction is outstanding at a time, and every memory-side and
// requester-side output comes straight from a flop.
//
// state | meaning
// IDLE  | waiting for requests; arbitration happens only here
// RD    | lane refill in flight (mm_rd_o high)
// WR    | store write-back in flight (mm_wr_o high)
// RESP  | one-cycle rdy/done pulse to the granted requester

package segre_mm_pkg;
  typedef enum logic [1:0] {
    MEMOP_BYTE = 2'd0,
    MEMOP_HALF = 2'd1,
    MEMOP_WORD = 2'd2
  } memop_data_type_e;
endpackage

module segre_mm_arbiter
  import segre_mm_pkg::*;
#(
  parameter int ADDR_SIZE = 32,
  parameter int WORD_SIZE = 32,
  parameter int LANE_SIZE = 128
) (
  input  logic                 clk_i,
  input  logic                 rsn_i,
  input  logic                 ic_req_i,
  input  logic [ADDR_SIZE-1:0] ic_addr_i,
  output logic                 ic_rdy_o,
  output logic [LANE_SIZE-1:0] ic_data_o,
  input  logic                 dc_req_i,
  input  logic [ADDR_SIZE-1:0] dc_addr_i,
  output logic                 dc_rdy_o,
  output logic [LANE_SIZE-1:0] dc_data_o,
  input  logic                 wr_req_i,
  input  logic [ADDR_SIZE-1:0] wr_addr_i,
  input  logic [WORD_SIZE-1:0] wr_data_i,
  input  memop_data_type_e     wr_type_i,
  output logic                 wr_done_o,
  input  logic                 mm_data_rdy_i,
  input  logic [LANE_SIZE-1:0] mm_rd_data_i,
  output logic                 mm_rd_o,
  output logic                 mm_wr_o,
  output logic [ADDR_SIZE-1:0] mm_addr_o,
  output logic [ADDR_SIZE-1:0] mm_wr_addr_o,
  output logic [WORD_SIZE-1:0] mm_wr_data_o,
  output memop_data_type_e     mm_wr_data_type_o
);

  localparam int OFF_BITS = $clog2(LANE_SIZE / 8);
  // Refill addresses are lane aligned: byte-offset bits are cleared.
  localparam logic [ADDR_SIZE-1:0] LANE_MASK = {ADDR_SIZE{1'b1}} << OFF_BITS;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;
  typedef enum logic [1:0] {GNT_IC, GNT_DC, GNT_WR} gnt_e;

  state_e     state_q, state_d;
  gnt_e       gnt_q;
  gnt_e       win;
  logic       any_req;
  logic [1:0] starve_q, starve_d;

  // Pick the winner: a starved ic beats everyone, otherwise wr > dc > ic.
  always_comb begin
    any_req = ic_req_i | dc_req_i | wr_req_i;
    win     = GNT_IC;
    if (ic_req_i && starve_q == 2'd2) begin
      win = GNT_IC;
    end else if (wr_req_i) begin
      win = GNT_WR;
    end else if (dc_req_i) begin
      win = GNT_DC;
    end
  end

  // Next state and starvation counter; the counter only moves on a grant.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = (win == GNT_WR) ? WR : RD;
          if (!ic_req_i || win == GNT_IC) begin
            starve_d = 2'd0;
          end else begin
            starve_d = starve_q + 2'd1;
          end
        end
      end
      RD, WR: begin
        if (mm_data_rdy_i) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and starvation counter registers.
  always_ff @(posedge clk_i or posedge rsn_i) begin
    if (rsn_i) begin
      state_q  <= IDLE;
      starve_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Registered outputs: grant captures the request, completion drops the
  // memory strobe, captures refill data and raises the one-cycle pulse.
  always_ff @(posedge clk_i or posedge rsn_i) begin
    if (rsn_i) begin
      gnt_q             <= GNT_IC;
      ic_rdy_o          <= 1'b0;
      dc_rdy_o          <= 1'b0;
      wr_done_o         <= 1'b0;
      ic_data_o         <= '0;
      dc_data_o         <= '0;
      mm_rd_o           <= 1'b0;
      mm_wr_o           <= 1'b0;
      mm_addr_o         <= '0;
      mm_wr_addr_o      <= '0;
      mm_wr_data_o      <= '0;
      mm_wr_data_type_o <= MEMOP_BYTE;
    end else begin
      ic_rdy_o  <= 1'b0;
      dc_rdy_o  <= 1'b0;
      wr_done_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            gnt_q <= win;
            case (win)
              GNT_WR: begin
                mm_wr_o           <= 1'b1;
                mm_wr_addr_o      <= wr_addr_i;
                mm_wr_data_o      <= wr_data_i;
                mm_wr_data_type_o <= wr_type_i;
              end
              GNT_DC: begin
                mm_rd_o   <= 1'b1;
                mm_addr_o <= dc_addr_i & LANE_MASK;
              end
              default: begin
                mm_rd_o   <= 1'b1;
                mm_addr_o <= ic_addr_i & LANE_MASK;
              end
            endcase
          end
        end
        RD: begin
          if (mm_data_rdy_i) begin
            mm_rd_o <= 1'b0;
            if (gnt_q == GNT_DC) begin
              dc_data_o <= mm_rd_data_i;
              dc_rdy_o  <= 1'b1;
            end else begin
              ic_data_o <= mm_rd_data_i;
              ic_rdy_o  <= 1'b1;
            end
          end
        end
        WR: begin
          if (mm_data_rdy_i) begin
            mm_wr_o   <= 1'b0;
            wr_done_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_segre_mm_arbiter.sv
// Bench for segre_mm_arbiter: directed scenarios followed by random traffic,
// all checked against a transaction-level model of grants and timing.
`timescale 1ns/1ps
module tb_segre_mm_arbiter;
  import segre_mm_pkg::*;

  localparam int AW = 32;
  localparam int WW = 32;
  localparam int LW = 128;
  localparam logic [AW-1:0] LANE_BYTES = AW'(LW / 8);

  logic clk = 1'b0;
  logic rst;
  logic ic_req, dc_req, wr_req;
  logic [AW-1:0] ic_addr, dc_addr, wr_addr;
  logic [WW-1:0] wr_data;
  memop_data_type_e wr_type;
  logic ic_rdy, dc_rdy, wr_done;
  logic [LW-1:0] ic_data, dc_data;
  logic mm_data_rdy;
  logic [LW-1:0] mm_rd_data;
  logic mm_rd, mm_wr;
  logic [AW-1:0] mm_addr, mm_wr_addr;
  logic [WW-1:0] mm_wr_data;
  memop_data_type_e mm_wr_type;

  always #5 clk = ~clk;

  segre_mm_arbiter #(.ADDR_SIZE(AW), .WORD_SIZE(WW), .LANE_SIZE(LW)) dut (
    .clk_i(clk), .rsn_i(rst),
    .ic_req_i(ic_req), .ic_addr_i(ic_addr), .ic_rdy_o(ic_rdy), .ic_data_o(ic_data),
    .dc_req_i(dc_req), .dc_addr_i(dc_addr), .dc_rdy_o(dc_rdy), .dc_data_o(dc_data),
    .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_type_i(wr_type),
    .wr_done_o(wr_done),
    .mm_data_rdy_i(mm_data_rdy), .mm_rd_data_i(mm_rd_data),
    .mm_rd_o(mm_rd), .mm_wr_o(mm_wr), .mm_addr_o(mm_addr), .mm_wr_addr_o(mm_wr_addr),
    .mm_wr_data_o(mm_wr_data), .mm_wr_data_type_o(mm_wr_type)
  );

  int n_checks = 0, n_pass = 0, n_fail = 0;

  // Transaction-level model: who holds the memory port (-1 none, 0 ic, 1 dc,
  // 2 wr), grant cycle, completion cycle and first cycle arbitration may run.
  int k, free_at, gnt, done, who, starve, lat;
  logic [AW-1:0] t_addr;
  logic [WW-1:0] t_data;
  memop_data_type_e t_type;
  logic [LW-1:0] t_lane, exp_ic_data, exp_dc_data;
  int fixed_lat, spur_pct;
  logic fixed_lane_en;
  logic [LW-1:0] fixed_lane;
  int rd_cycles, n_ic_rdy, n_dc_rdy, n_wr_done;
  int obs_order[$];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic arbitrate();
    if (ic_req && starve == 2) who = 0;
    else if (wr_req) who = 2;
    else if (dc_req) who = 1;
    else who = 0;
    starve = (!ic_req || who == 0) ? 0 : starve + 1;
    gnt  = k;
    lat  = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
    done = k + lat;
    t_lane = fixed_lane_en ? fixed_lane : {$urandom(), $urandom(), $urandom(), $urandom()};
    case (who)
      0:       t_addr = ic_addr;
      1:       t_addr = dc_addr;
      default: t_addr = wr_addr;
    endcase
    t_data = wr_data;
    t_type = wr_type;
  endtask

  // One clock: settle this cycle's inputs, then check the next cycle's outputs.
  task automatic tick();
    logic in_flight, e_rd, e_wr, e_ic, e_dc, e_wd;
    if (who < 0 && k >= free_at && (ic_req || dc_req || wr_req)) arbitrate();
    in_flight   = (who >= 0) && (k > gnt) && (k <= done);
    mm_data_rdy = (in_flight && k == done) ||
                  (!in_flight && int'($urandom_range(0, 99)) < spur_pct);
    mm_rd_data  = (in_flight && k == done) ? t_lane
                                           : {$urandom(), $urandom(), $urandom(), $urandom()};
    @(negedge clk);
    k++;
    if (mm_rd)   rd_cycles++;
    if (ic_rdy)  begin n_ic_rdy++;  obs_order.push_back(0); end
    if (dc_rdy)  begin n_dc_rdy++;  obs_order.push_back(1); end
    if (wr_done) begin n_wr_done++; obs_order.push_back(2); end
    e_rd = (who == 0 || who == 1) && k > gnt && k <= done;
    e_wr = (who == 2) && k > gnt && k <= done;
    e_ic = (who == 0) && k == done + 1;
    e_dc = (who == 1) && k == done + 1;
    e_wd = (who == 2) && k == done + 1;
    chk("ctrl", {mm_rd, mm_wr, ic_rdy, dc_rdy, wr_done}, {e_rd, e_wr, e_ic, e_dc, e_wd});
    if (who >= 0 && k == gnt + 1) begin
      if (who == 2) chk("wr_req", {mm_wr_addr, mm_wr_data, mm_wr_type}, {t_addr, t_data, t_type});
      else          chk("rd_addr", mm_addr, t_addr - (t_addr % LANE_BYTES));
    end
    if (who >= 0 && k == done + 1) begin
      if (who == 0) begin exp_ic_data = t_lane; ic_req = 1'b0; end
      else if (who == 1) begin exp_dc_data = t_lane; dc_req = 1'b0; end
      else wr_req = 1'b0;
      who = -1;
      free_at = k + 1;
    end
    chk("lanes", {ic_data, dc_data}, {exp_ic_data, exp_dc_data});
  endtask

  task automatic drain(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (who < 0 && !ic_req && !dc_req && !wr_req) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s_drain: observed busy expected idle", tag);
    end
  endtask

  task automatic to_first_req_cycle(input int id);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (who == id && k == gnt + 1) break;
    end
  endtask

  initial begin
    int ic_pos;
    rst = 1'b0; ic_req = 0; dc_req = 0; wr_req = 0;
    ic_addr = '0; dc_addr = '0; wr_addr = '0; wr_data = '0; wr_type = MEMOP_BYTE;
    mm_data_rdy = 0; mm_rd_data = '0;
    who = -1; k = 0; free_at = 0; starve = 0; gnt = 0; done = 0;
    exp_ic_data = '0; exp_dc_data = '0;
    fixed_lat = 0; fixed_lane_en = 0; fixed_lane = '0; spur_pct = 0;
    rd_cycles = 0; n_ic_rdy = 0; n_dc_rdy = 0; n_wr_done = 0;

    // Reset values, asynchronously and while clocks run.
    #1 rst = 1'b1;
    #1;
    chk("reset_ctl", {mm_rd, mm_wr, ic_rdy, dc_rdy, wr_done}, 5'b0);
    chk("reset_addr", {mm_addr, mm_wr_addr, mm_wr_data}, '0);
    chk("reset_type", mm_wr_type, MEMOP_BYTE);
    chk("reset_lanes", {ic_data, dc_data}, '0);
    @(negedge clk);
    @(negedge clk);
    chk("reset_hold", {mm_rd, mm_wr, ic_rdy, dc_rdy, wr_done, mm_addr}, '0);
    rst = 1'b0;
    free_at = k;

    // Single ic refill, memory ready 3 cycles after the request appears.
    ic_addr = 32'h0000_1234; ic_req = 1'b1;
    fixed_lat = 3; fixed_lane_en = 1'b1;
    fixed_lane = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
    rd_cycles = 0; n_ic_rdy = 0;
    to_first_req_cycle(0);
    chk("r027_addr", mm_addr, 32'h0000_1230);
    drain("r027");
    chk("r027_rd_cycles", rd_cycles, 3);
    chk("r027_rdy_count", n_ic_rdy, 1);
    chk("r027_data", ic_data, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE);
    fixed_lane_en = 1'b0;

    // Spurious memory completions while idle and around a transaction.
    spur_pct = 100; n_ic_rdy = 0; n_dc_rdy = 0; n_wr_done = 0;
    repeat (5) tick();
    chk("r031_no_pulse", n_ic_rdy + n_dc_rdy + n_wr_done, 0);
    ic_addr = 32'h0000_2008; ic_req = 1'b1; fixed_lat = 2;
    drain("r031");
    chk("r031_one_rdy", n_ic_rdy, 1);
    spur_pct = 0;

    // Byte store write-back.
    wr_addr = 32'h0000_0102; wr_data = 32'h0000_00AB; wr_type = MEMOP_BYTE; wr_req = 1'b1;
    fixed_lat = 2; n_wr_done = 0;
    to_first_req_cycle(2);
    chk("r032_wr", mm_wr, 1'b1);
    chk("r032_addr", mm_wr_addr, 32'h0000_0102);
    chk("r032_data", mm_wr_data, 32'h0000_00AB);
    chk("r032_type", mm_wr_type, MEMOP_BYTE);
    drain("r032");
    chk("r032_done_count", n_wr_done, 1);

    // All three requesters at once: service order wr, dc, ic.
    fixed_lat = 0; obs_order.delete();
    n_ic_rdy = 0; n_dc_rdy = 0; n_wr_done = 0;
    ic_addr = 32'h0000_3010; dc_addr = 32'h0000_4020;
    wr_addr = 32'h0000_5031; wr_data = 32'h1234_5678; wr_type = MEMOP_WORD;
    ic_req = 1'b1; dc_req = 1'b1; wr_req = 1'b1;
    drain("r028");
    chk("r028_count", obs_order.size(), 3);
    if (obs_order.size() == 3) begin
      chk("r028_first", obs_order[0], 2);
      chk("r028_second", obs_order[1], 1);
      chk("r028_third", obs_order[2], 0);
    end
    chk("r028_pulses", {n_ic_rdy[7:0], n_dc_rdy[7:0], n_wr_done[7:0]}, 24'h01_01_01);

    // ic held while wr and dc keep re-requesting: starvation guard.
    obs_order.delete();
    ic_addr = 32'h0000_6000; ic_req = 1'b1;
    wr_req = 1'b1; dc_req = 1'b1;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (ic_req == 1'b0) break;
      if (!wr_req) begin wr_addr = $urandom(); wr_data = $urandom(); wr_req = 1'b1; end
      if (!dc_req) begin dc_addr = $urandom(); dc_req = 1'b1; end
    end
    ic_pos = -1;
    foreach (obs_order[i]) if (obs_order[i] == 0 && ic_pos < 0) ic_pos = i;
    chk("r029_ic_pos", ic_pos, 2);
    drain("r029");

    // Reset during a refill abandons it with no pulse.
    dc_addr = 32'h0000_4444; dc_req = 1'b1; fixed_lat = 6;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (who == 1 && k == gnt + 2) break;
    end
    chk("r030_pre_rd", mm_rd, 1'b1);
    rst = 1'b1;
    dc_req = 1'b0;
    mm_data_rdy = 1'b0;
    #1;
    chk("r030_rd_drop", {mm_rd, mm_wr, ic_rdy, dc_rdy, wr_done}, 5'b0);
    @(negedge clk); k++;
    chk("r030_hold", {mm_rd, mm_wr, ic_rdy, dc_rdy, wr_done}, 5'b0);
    chk("r030_lanes", {ic_data, dc_data}, '0);
    rst = 1'b0;
    who = -1; starve = 0; free_at = k;
    exp_ic_data = '0; exp_dc_data = '0;
    n_dc_rdy = 0;
    dc_addr = 32'h0000_555C; dc_req = 1'b1; fixed_lat = 2;
    drain("r030");
    chk("r030_recover", n_dc_rdy, 1);

    // Random traffic with spurious completions.
    fixed_lat = 0; spur_pct = 20;
    for (int i = 0; i < 600; i++) begin
      if (!ic_req && $urandom_range(0, 3) == 0) begin ic_addr = $urandom(); ic_req = 1'b1; end
      if (!dc_req && $urandom_range(0, 3) == 0) begin dc_addr = $urandom(); dc_req = 1'b1; end
      if (!wr_req && $urandom_range(0, 3) == 0) begin
        wr_addr = $urandom(); wr_data = $urandom();
        wr_type = memop_data_type_e'($urandom_range(0, 2));
        wr_req = 1'b1;
      end
      tick();
    end
    spur_pct = 0;
    drain("random");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
